vga_capture: RTL

- Receive end of the 640x480@60 VGA link that the NES display path produces: sync, blank and RGB888.
- Measures the incoming line and frame timing and locks onto it.
- Takes the 512-pixel picture window (hcnt 64..575), downscales it 2:1 in both axes and quantises it.
- Emits 256x240 framebuffer writes addressed {y[7:0],x[7:0]}, the same write-port shape the display path uses.
- Used for loopback self-test and frame grabbing.

---
 rtl/vga_capture.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// VGA receive side: locks to 640x480 timing, downsamples the 512-pixel window 2:1 into 256x240 framebuffer writes.
// Build option CAPTURE_AVG_EN: average each horizontal pixel pair instead of dropping the odd pixel.
module vga_capture #(
  parameter int H_WIN_START = 64,
  parameter int H_WIN_WIDTH = 512,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 4
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_HSYNC,
  input  logic        I_VSYNC,
  input  logic        I_BLANK,
  input  logic [7:0]  I_RED,
  input  logic [7:0]  I_GREEN,
  input  logic [7:0]  I_BLUE,
  output logic [5:0]  O_COLOR,
  output logic [15:0] O_ADDR,
  output logic        O_WREN,
  output logic [9:0]  O_HTOTAL,
  output logic [9:0]  O_VTOTAL,
  output logic        O_LOCKED,
  output logic        O_FRAME_START
);

  localparam int CW = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0] WS  = 10'(H_WIN_START);
  localparam logic [9:0] WE  = 10'(H_WIN_START + H_WIN_WIDTH);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [8:0] WS9 = 9'(H_WIN_START);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  logic          hs1, vs1, bl1, hs2, vs2, bl2;
  logic [7:0]    r1, g1, b1;
  logic [9:0]    pcnt, lcnt, prev_per, hcnt, vline, ref_h, ref_v;
  logic          first_line, frame_bad;
  state_t        state;
  logic [CW-1:0] cnt;

  logic       hs_fall, vs_fall, bl_fall, match, in_win, take;
  logic [9:0] pcnt_inc, h_next, hcnt_cur, vline_cur;
  logic [8:0] win;
  logic [5:0] col;

  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) begin
      {hs1, vs1, bl1, hs2, vs2, bl2} <= '0;
      {r1, g1, b1} <= '0;
    end else begin
      {hs1, vs1, bl1} <= {I_HSYNC, I_VSYNC, I_BLANK};
      {r1, g1, b1}    <= {I_RED, I_GREEN, I_BLUE};
      {hs2, vs2, bl2} <= {hs1, vs1, bl1};
    end

  assign hs_fall  = hs2 & ~hs1;
  assign vs_fall  = vs2 & ~vs1;
  assign bl_fall  = bl2 & ~bl1;
  assign pcnt_inc = (pcnt == 10'h3FF) ? pcnt : pcnt + 10'd1;
  assign h_next   = hs_fall ? pcnt_inc : O_HTOTAL;
  assign match    = (h_next == ref_h) && (lcnt == ref_v) && !frame_bad;

  // hcnt/vline registers hold the previous pixel's position; *_cur is the stage-1 pixel's.
  assign hcnt_cur  = bl_fall ? 10'd0 : ((hcnt == 10'h3FF) ? hcnt : hcnt + 10'd1);
  assign vline_cur = bl_fall ? vline + 10'd1 : vline;
  assign win       = hcnt_cur[8:0] - WS9;
  assign in_win    = !bl1 && (hcnt_cur >= WS) && (hcnt_cur < WE) &&
                     (vline_cur < VA) && !vline_cur[0] && O_LOCKED;

  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) begin
      pcnt <= '0; lcnt <= '0; prev_per <= '0; hcnt <= '0;
      vline <= 10'h3FF;
      first_line <= 1'b1; frame_bad <= 1'b0;
      O_HTOTAL <= '0; O_VTOTAL <= '0; O_FRAME_START <= 1'b0;
    end else begin
      pcnt <= hs_fall ? 10'd0 : pcnt_inc;
      if (hs_fall) begin
        O_HTOTAL   <= pcnt_inc;
        prev_per   <= pcnt_inc;
        first_line <= 1'b0;
        if (!first_line && pcnt_inc != prev_per) frame_bad <= 1'b1;
        if (lcnt != 10'h3FF) lcnt <= lcnt + 10'd1;
      end
      // placed after the hsync branch so a coincident vsync fall wins
      if (vs_fall) begin
        O_VTOTAL   <= lcnt;
        lcnt       <= '0;
        frame_bad  <= 1'b0;
        first_line <= 1'b1;
      end
      O_FRAME_START <= vs_fall;
      hcnt  <= hcnt_cur;
      vline <= vs_fall ? 10'h3FF : vline_cur;
    end

  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) begin
      state <= UNLOCKED; cnt <= '0;
      ref_h <= '0; ref_v <= '0;
      O_LOCKED <= 1'b0;
    end else if (vs_fall) begin
      case (state)
        UNLOCKED: begin
          state <= CHECK; cnt <= CW'(1);
          ref_h <= h_next; ref_v <= lcnt;
        end
        CHECK:
          if (match) begin
            cnt <= cnt + CW'(1);
            if (cnt >= CW'(LOCK_FRAMES - 1)) begin
              state <= LOCKED; O_LOCKED <= 1'b1;
            end
          end else begin
            ref_h <= h_next; ref_v <= lcnt; cnt <= CW'(1);
          end
        LOCKED:
          if (!match) begin
            state <= UNLOCKED; O_LOCKED <= 1'b0;
          end
        default: begin
          state <= UNLOCKED; O_LOCKED <= 1'b0;
        end
      endcase
    end

`ifdef CAPTURE_AVG_EN
  logic [7:0] er, eg, eb;
  logic [8:0] ar, ag, ab;

  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) {er, eg, eb} <= '0;
    else if (!win[0]) {er, eg, eb} <= {r1, g1, b1};

  assign ar   = {1'b0, er} + {1'b0, r1};
  assign ag   = {1'b0, eg} + {1'b0, g1};
  assign ab   = {1'b0, eb} + {1'b0, b1};
  assign col  = {ar[8:7], ag[8:7], ab[8:7]};
  assign take = in_win & win[0];
`else
  logic unused_lo;
  assign unused_lo = ^{r1[5:0], g1[5:0], b1[5:0]};
  assign col  = {r1[7:6], g1[7:6], b1[7:6]};
  assign take = in_win & ~win[0];
`endif

  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) begin
      O_WREN <= 1'b0; O_ADDR <= '0; O_COLOR <= '0;
    end else begin
      O_WREN <= take;
      if (take) begin
        O_ADDR  <= {vline_cur[8:1], win[8:1]};
        O_COLOR <= col;
      end
    end

endmodule
